// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c} through 0..7, holds each vector SETTLE_CYCLES cycles, then samples y into table_out.
// Define TRUTH_TABLE_COMPARE_EN to add a popcount compare of table_out against `expected`.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y,
  input  logic [7:0] expected,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       mismatch,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [2:0] index;
  logic [3:0] settle_cnt;

`ifdef TRUTH_TABLE_COMPARE_EN
  logic [7:0] diff;
  logic [3:0] err_count_next;

  // table_out already holds the bit-7 sample by the time the FSM sits in DONE
  assign diff           = table_out ^ expected;
  assign err_count_next = 4'($countones(diff));
`else
  logic unused_expected;

  assign unused_expected = ^expected;
  assign mismatch        = 1'b0;
  assign err_count       = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= 3'd0;
      settle_cnt <= 4'd0;
      {a, b, c}  <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= 8'h00;
`ifdef TRUTH_TABLE_COMPARE_EN
      mismatch   <= 1'b0;
      err_count  <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            index      <= 3'd0;
            settle_cnt <= SETTLE_LOAD;
            table_out  <= 8'h00;
            {a, b, c}  <= 3'd0;
            busy       <= 1'b1;
            state      <= SETTLE;
`ifdef TRUTH_TABLE_COMPARE_EN
            mismatch   <= 1'b0;
            err_count  <= 4'd0;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd1) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          table_out[index] <= y;
          if (index == 3'd7) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            {a, b, c} <= 3'd0;
            state     <= DONE;
          end else begin
            index      <= index + 3'd1;
            settle_cnt <= SETTLE_LOAD;
            {a, b, c}  <= index + 3'd1;
            state      <= SETTLE;
          end
        end
        DONE: begin
`ifdef TRUTH_TABLE_COMPARE_EN
          err_count <= err_count_next;
          mismatch  <= (err_count_next != 4'd0);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage wrapped around a 3-input combinational function block (a, b, c -> y).
- On `start`, drives all eight input combinations in order 0..7 and waits a programmable settle time for each.
- Samples the function output `y` for each combination and assembles an 8-bit truth-table word for the lab board LEDs.
- Sits directly upstream of the function block (feeds `a`, `b`, `c`) and directly downstream of it (consumes `y`).

Parameters:
- SETTLE_CYCLES, 2: clock cycles each input vector is held before `y` is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- y  input  1  output of the function block under sweep.
- a  output  1  function input a, MSB of the vector index.
- b  output  1  function input b.
- c  output  1  function input c, LSB of the vector index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  8  captured truth table; bit i = y for {a,b,c} = i.
- expected  input  8  reference truth table (used only with COMPARE_EN).
- mismatch  output  1  table_out differs from expected (COMPARE_EN only).
- err_count  output  4  number of differing bits, 0..8 (COMPARE_EN only).

Behaviour:
- One clock; reset is synchronous and active-high; ports are named clk and reset.
- Reset values: a=b=c=0, busy=0, done=0, table_out=8'h00, mismatch=0, err_count=0, state=IDLE, index=0, settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - a,b,c = 0; busy = 0.
  - start=1 -> index=0, settle counter=SETTLE_CYCLES, table_out cleared to 0 -> SETTLE.
- SETTLE:
  - {a,b,c} = index (registered).
  - busy = 1.
  - Counter decrements each cycle; when the counter equals 1 -> SAMPLE.
  - Duration is exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - {a,b,c} still = index; table_out[index] <= y.
  - If index==7 -> DONE.
  - Otherwise index <= index+1, counter reloads to SETTLE_CYCLES -> SETTLE.
- DONE (1 cycle):
  - done = 1; busy = 0; a,b,c return to 0.
  - In COMPARE_EN builds, mismatch/err_count are updated here.
  - Next state is IDLE.
- Timing:
  - busy is high for exactly 8*(SETTLE_CYCLES+1) cycles.
  - done is high in the cycle immediately after busy falls.
- Outputs a, b, c only change on SETTLE entry; they are stable throughout SETTLE and SAMPLE.
- table_out holds its value from DONE until the next accepted start.
- start in SETTLE/SAMPLE/DONE is ignored; there is no queuing.
- start held high continuously: each DONE is followed by one IDLE cycle, then a new sweep.
- Reset mid-sweep: the next cycle matches the reset values; the partial table is discarded.
- Index wrap: index never exceeds 7; a 3-bit counter is sufficient.

Optional Feature:
- Macro: TRUTH_TABLE_COMPARE_EN.
- When defined:
  - In DONE, err_count <= popcount(table_out_final XOR expected).
  - mismatch <= (err_count_next != 0).
  - table_out_final includes the bit-7 sample written in the preceding SAMPLE cycle.
  - Both outputs hold until the next accepted start, which clears them to 0.
- When undefined:
  - mismatch and err_count are tied to 0.
  - expected is unused.
  - No compare logic is synthesised.

Test Plan:
- y driven by F = ab' + b'c' + a'bc (combinational from a,b,c), SETTLE_CYCLES=2, pulse start -> busy high 24 cycles, done pulse, table_out=8'h39.
- y tied 0 / y = a / y = c -> table_out = 8'h00 / 8'hF0 / 8'hAA respectively.
- Vector timing check -> {a,b,c} steps 0..7, each held exactly SETTLE_CYCLES+1 cycles; start pulses while busy produce no restart.
- reset asserted during vector 4 -> next cycle busy=0, a=b=c=0, table_out=0; a new start then yields a full correct sweep.
- COMPARE_EN, F as above: expected=8'h39 -> mismatch=0, err_count=0; expected=8'hFF with y tied 0 -> mismatch=1, err_count=8.
- start held high for 3 sweeps -> three done pulses spaced 8*(SETTLE_CYCLES+1)+2 cycles apart; table_out correct after each.
